control_unit: RTL and testbench



---
 rtl/control_unit.sv | 172 +++++++++++++++++
 tb/tb_control_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Five-state sequencer for the cs147sec05 processor: latches the fetched
// instruction and decodes it into the data path CTRL word and memory strobes.
module control_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  output logic [31:0] CTRL,
  output logic        READ,
  output logic        WRITE
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_MULI = 6'h1d,
                         OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f,
                         OP_SLTI  = 6'h0a, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                         OP_LW    = 6'h23, OP_SW   = 6'h2b, OP_JMP  = 6'h02,
                         OP_JAL   = 6'h03, OP_PUSH = 6'h1b, OP_POP  = 6'h1c;

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_MUL = 6'h2c,
                         FN_AND = 6'h24, FN_OR  = 6'h25, FN_NOR = 6'h27,
                         FN_SLT = 6'h2a, FN_SLL = 6'h01, FN_SRL = 6'h02,
                         FN_JR  = 6'h08;

  localparam logic [5:0] ALU_NONE = 6'd0, ALU_ADD = 6'd1, ALU_SUB = 6'd2,
                         ALU_MUL  = 6'd3, ALU_SHR = 6'd4, ALU_SHL = 6'd5,
                         ALU_AND  = 6'd6, ALU_OR  = 6'd7, ALU_NOR = 6'd8,
                         ALU_SLT  = 6'd9;

  localparam logic [31:0] B_IR_LOAD = 32'h0000_0010, B_SP_LOAD = 32'h0000_0020,
                          B_REG_R   = 32'h0000_0040, B_REG_W   = 32'h0000_0080,
                          B_OP1     = 32'h0000_0100, B_OP2_1   = 32'h0000_0200,
                          B_OP2_2   = 32'h0000_0400, B_OP2_3   = 32'h0000_0800,
                          B_OP2_4   = 32'h0000_1000, B_WD_1    = 32'h0000_2000,
                          B_WD_2    = 32'h0000_4000, B_WD_3    = 32'h0000_8000,
                          B_R1_1    = 32'h0001_0000, B_WA_1    = 32'h0002_0000,
                          B_WA_2    = 32'h0004_0000, B_WA_3    = 32'h0008_0000,
                          B_MA_1    = 32'h0010_0000, B_MA_2    = 32'h0020_0000,
                          B_MD_1    = 32'h0040_0000;

  localparam logic [31:0] FETCH_VEC = B_MA_2 | B_IR_LOAD;
  localparam logic [31:0] WB_RTYPE  = B_REG_W | B_WA_3 | B_WD_3;
  localparam logic [31:0] WB_ITYPE  = WB_RTYPE | B_WA_1;

  localparam logic [3:0] PC_NEXT = 4'hB, PC_BRANCH = 4'hF, PC_JR = 4'h9, PC_JUMP = 4'h1;

  state_t      state;
  logic [31:0] il;
  logic [5:0]  opcode, funct, alu_op;
  logic [31:0] exe_bits, mem_bits, wb_bits;
  logic [31:0] exe_vec, mem_vec, wb_vec;
  logic [3:0]  pc_bits;
  logic        mem_rd, mem_wr;
  logic        unused_fields;

  assign opcode = il[31:26];
  assign funct  = il[5:0];
  // Register and immediate fields are routed by the data path, not decoded here.
  assign unused_fields = ^il[25:6];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= FETCH;
      il    <= '0;
    end else begin
      case (state)
        FETCH: begin
          il    <= INSTRUCTION;
          state <= DECODE;
        end
        DECODE:    state <= EXECUTE;
        EXECUTE:   state <= MEMORY;
        MEMORY:    state <= WRITEBACK;
        WRITEBACK: state <= FETCH;
        default:   state <= FETCH;
      endcase
    end
  end

  always_comb begin
    alu_op   = ALU_NONE;
    exe_bits = '0;
    mem_bits = '0;
    wb_bits  = '0;
    pc_bits  = PC_NEXT;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_MUL:  alu_op = ALU_MUL;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SHL;
          FN_SRL:  alu_op = ALU_SHR;
          FN_JR:   pc_bits = PC_JR;
          default: ;
        endcase
        if (funct == FN_SLL || funct == FN_SRL) exe_bits = B_OP2_1 | B_OP2_3;
        else if (alu_op != ALU_NONE)            exe_bits = B_OP2_4;
        if (alu_op != ALU_NONE) wb_bits = WB_RTYPE;
      end
      OP_ADDI: begin alu_op = ALU_ADD; exe_bits = B_OP2_2; wb_bits = WB_ITYPE; end
      OP_MULI: begin alu_op = ALU_MUL; exe_bits = B_OP2_2; wb_bits = WB_ITYPE; end
      OP_SLTI: begin alu_op = ALU_SLT; exe_bits = B_OP2_2; wb_bits = WB_ITYPE; end
      OP_ANDI: begin alu_op = ALU_AND; wb_bits = WB_ITYPE; end
      OP_ORI:  begin alu_op = ALU_OR;  wb_bits = WB_ITYPE; end
      OP_LUI:  wb_bits = WB_ITYPE | B_WD_2;
      OP_LW: begin
        alu_op = ALU_ADD; exe_bits = B_OP2_2; mem_rd = 1'b1; wb_bits = WB_ITYPE | B_WD_1;
      end
      OP_SW: begin alu_op = ALU_ADD; exe_bits = B_OP2_2; mem_wr = 1'b1; end
      OP_BEQ: begin
        alu_op = ALU_SUB; exe_bits = B_OP2_4;
        if (ZERO) pc_bits = PC_BRANCH;
      end
      OP_BNE: begin
        alu_op = ALU_SUB; exe_bits = B_OP2_4;
        if (!ZERO) pc_bits = PC_BRANCH;
      end
      OP_JMP: pc_bits = PC_JUMP;
      OP_JAL: begin pc_bits = PC_JUMP; wb_bits = B_REG_W | B_WA_2; end
      // Push stores r0 at SP and decrements SP afterwards; pop increments SP first.
      OP_PUSH: begin
        alu_op = ALU_SUB; exe_bits = B_OP1 | B_OP2_3 | B_R1_1;
        mem_wr = 1'b1; mem_bits = B_MA_1 | B_MD_1; wb_bits = B_SP_LOAD;
      end
      OP_POP: begin
        alu_op = ALU_ADD; exe_bits = B_OP1 | B_OP2_3 | B_SP_LOAD;
        mem_rd = 1'b1; mem_bits = B_MA_1; wb_bits = B_REG_W | B_WD_1 | B_WD_3;
      end
      default: ;
    endcase
  end

  assign exe_vec = {alu_op, 26'b0} | exe_bits | B_REG_R;
  assign mem_vec = (exe_vec & ~B_SP_LOAD) | mem_bits;
  assign wb_vec  = mem_vec | wb_bits | {28'b0, pc_bits};

  // Outputs are forced low for as long as reset is held, whatever the state.
  always_comb begin
    CTRL  = '0;
    READ  = 1'b0;
    WRITE = 1'b0;
    if (RST) begin
      case (state)
        FETCH: begin
          CTRL = FETCH_VEC;
          READ = 1'b1;
        end
        DECODE:  CTRL = B_REG_R | (exe_bits & B_R1_1);
        EXECUTE: CTRL = exe_vec;
        MEMORY: begin
          CTRL  = mem_vec;
          READ  = mem_rd;
          WRITE = mem_wr;
        end
        WRITEBACK: begin
          CTRL = wb_vec;
          READ = mem_rd;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of instructions with hand-computed per-state
// CTRL/READ/WRITE values, plus reset and mid-instruction abort sequences.
module tb_control_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic        READ;
  logic        WRITE;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]      instr;
    logic             zero;
    logic [4:0][31:0] ctrl;
    logic [31:0]      mask;
    logic [4:0]       rd;
    logic [4:0]       wr;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  control_unit dut (
    .CLK(CLK),
    .RST(RST),
    .INSTRUCTION(INSTRUCTION),
    .ZERO(ZERO),
    .CTRL(CTRL),
    .READ(READ),
    .WRITE(WRITE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic [31:0] instr, input logic zero,
                              input logic [31:0] c1, input logic [31:0] c2,
                              input logic [31:0] c3, input logic [31:0] c4,
                              input logic [31:0] mask, input logic [4:0] rd,
                              input logic [4:0] wr);
    vec_t v;
    v.instr   = instr;
    v.zero    = zero;
    v.ctrl[0] = 32'h0020_0010;
    v.ctrl[1] = c1;
    v.ctrl[2] = c2;
    v.ctrl[3] = c3;
    v.ctrl[4] = c4;
    v.mask    = mask;
    v.rd      = rd;
    v.wr      = wr;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] exp_ctrl,
                              input logic [31:0] mask, input logic exp_rd,
                              input logic exp_wr);
    checks++;
    if (((CTRL & mask) !== (exp_ctrl & mask)) || (READ !== exp_rd) || (WRITE !== exp_wr)) begin
      errors++;
      $display("[TB] FAIL %s: got CTRL=%h READ=%b WRITE=%b, expected CTRL=%h READ=%b WRITE=%b (mask %h)",
               name, CTRL, READ, WRITE, exp_ctrl, exp_rd, exp_wr, mask);
    end
  endtask

  // Starts in FETCH; leaves the DUT in the next FETCH, 1 ns after the edge.
  task automatic apply_stimulus(input vec_t v, input int idx);
    INSTRUCTION = v.instr;
    ZERO        = v.zero;
    #1;
    check_output($sformatf("v%0d_%h_s0", idx, v.instr), v.ctrl[0], '1, v.rd[0], v.wr[0]);
    for (int s = 1; s < 5; s++) begin
      @(posedge CLK);
      #1;
      if (s == 1) INSTRUCTION = 32'hFFFF_FFFF;
      check_output($sformatf("v%0d_%h_s%0d", idx, v.instr, s), v.ctrl[s], v.mask, v.rd[s], v.wr[s]);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(32'h0109_5020, 1'b0, 32'h0000_0040, 32'h0400_1040, 32'h0400_1040, 32'h0408_90CB, '1,           5'b00001, 5'b00000);
    vecs[1]  = mk(32'h8D09_0004, 1'b0, 32'h0000_0040, 32'h0400_0440, 32'h0400_0440, 32'h040A_A4CB, 32'hFFF7_7FFF, 5'b11001, 5'b00000);
    vecs[2]  = mk(32'h1109_0003, 1'b1, 32'h0000_0040, 32'h0800_1040, 32'h0800_1040, 32'h0800_104F, '1,           5'b00001, 5'b00000);
    vecs[3]  = mk(32'h1109_0003, 1'b0, 32'h0000_0040, 32'h0800_1040, 32'h0800_1040, 32'h0800_104B, '1,           5'b00001, 5'b00000);
    vecs[4]  = mk(32'h0C00_0010, 1'b0, 32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 32'h0004_00C1, '1,           5'b00001, 5'b00000);
    vecs[5]  = mk(32'h6C00_0000, 1'b0, 32'h0001_0040, 32'h0801_0940, 32'h0851_0940, 32'h0851_096B, '1,           5'b00001, 5'b01000);
    vecs[6]  = mk(32'hAD09_0004, 1'b0, 32'h0000_0040, 32'h0400_0440, 32'h0400_0440, 32'h0400_044B, '1,           5'b00001, 5'b01000);
    vecs[7]  = mk(32'h7000_0000, 1'b0, 32'h0000_0040, 32'h0400_0960, 32'h0410_0940, 32'h0410_A9CB, 32'hFFFF_7FFF, 5'b11001, 5'b00000);
    vecs[8]  = mk(32'hFC00_0000, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 32'h0000_004B, 32'hFFFF_FFBF, 5'b00001, 5'b00000);
    vecs[9]  = mk(32'h2128_0005, 1'b0, 32'h0000_0040, 32'h0400_0440, 32'h0400_0440, 32'h040A_84CB, '1,           5'b00001, 5'b00000);
    vecs[10] = mk(32'h0009_4081, 1'b0, 32'h0000_0040, 32'h1400_0A40, 32'h1400_0A40, 32'h1408_8ACB, '1,           5'b00001, 5'b00000);
    vecs[11] = mk(32'h03E0_0008, 1'b0, 32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 32'h0000_0049, 32'h03FF_E1FF, 5'b00001, 5'b00000);
    vecs[12] = mk(32'h1509_0003, 1'b0, 32'h0000_0040, 32'h0800_1040, 32'h0800_1040, 32'h0800_104F, '1,           5'b00001, 5'b00000);
    vecs[13] = mk(32'h3128_000F, 1'b0, 32'h0000_0040, 32'h1800_0040, 32'h1800_0040, 32'h180A_80CB, '1,           5'b00001, 5'b00000);

    RST         = 1'b0;
    INSTRUCTION = 32'h0109_5020;
    ZERO        = 1'b0;

    // Reset held for three cycles keeps every output low.
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      check_output($sformatf("reset_hold_c%0d", c), 32'h0, '1, 1'b0, 1'b0);
    end
    RST = 1'b1;
    #1;
    check_output("reset_release_fetch", 32'h0020_0010, '1, 1'b1, 1'b0);
    #1;

    for (int i = 0; i < NVEC; i++) apply_stimulus(vecs[i], i);

    // Abort a store in MEMORY: WRITE must drop as soon as reset asserts.
    INSTRUCTION = 32'hAD09_0004;
    ZERO        = 1'b0;
    for (int s = 1; s < 4; s++) begin
      @(posedge CLK);
      #1;
      if (s == 1) INSTRUCTION = 32'h0000_0000;
    end
    check_output("abort_sw_memory", 32'h0400_0440, '1, 1'b0, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    check_output("abort_async_low", 32'h0, '1, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    check_output("abort_held_low", 32'h0, '1, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check_output("abort_release_fetch", 32'h0020_0010, '1, 1'b1, 1'b0);
    #1;

    apply_stimulus(vecs[0], 100);
    apply_stimulus(vecs[5], 101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
